// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-cache handshake, byte-lane strobes,
// load extraction and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_data2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_ls_word,
  output logic              dc_req,
  output logic              dc_we,
  output logic [DATA_W-1:0] dc_addr,
  output logic [3:0]        dc_wstrb,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic [DATA_W-1:0] dc_rdata,
  input  logic              dc_valid,
  output logic              d_stall,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [DATA_W-1:0] wb_alu,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_memtoreg,
  output logic              wb_regwrite
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              access;
  logic              is_write;
  logic              is_load;
  logic [3:0]        byte_strb;
  logic [7:0]        ld_byte;
  logic [DATA_W-1:0] ld_data;

  logic [DATA_W-1:0] wb_rdata_q, wb_alu_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic              wb_memtoreg_q, wb_regwrite_q;

  // A simultaneous read+write request is serviced as a write.
  assign access   = ex_memread | ex_memwrite;
  assign is_write = ex_memwrite;
  assign is_load  = ex_memread & ~ex_memwrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake and stall; everything is forced low while reset is asserted.
  always_comb begin
    state_d = state_q;
    dc_req  = 1'b0;
    d_stall = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            dc_req  = 1'b1;
            d_stall = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          dc_req = 1'b1;
          if (dc_valid) begin
            state_d = S_IDLE;
          end else begin
            d_stall = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign byte_strb = 4'b0001 << ex_result[1:0];
  assign dc_we     = dc_req & is_write;
  assign dc_addr   = {ex_result[DATA_W-1:2], 2'b00};
  assign dc_wstrb  = dc_we ? (ex_ls_word ? 4'b1111 : byte_strb) : 4'b0000;
  assign dc_wdata  = ex_ls_word ? ex_data2 : {(DATA_W/8){ex_data2[7:0]}};

  always_comb begin
    ld_byte = dc_rdata[7:0];
    case (ex_result[1:0])
      2'd0: ld_byte = dc_rdata[7:0];
      2'd1: ld_byte = dc_rdata[15:8];
      2'd2: ld_byte = dc_rdata[23:16];
      2'd3: ld_byte = dc_rdata[31:24];
    endcase
  end

  assign ld_data = ex_ls_word ? dc_rdata : {{(DATA_W-8){ld_byte[7]}}, ld_byte};

  // MEM/WB register: frozen together with the upstream pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_rdata_q    <= '0;
      wb_alu_q      <= '0;
      wb_rd_q       <= '0;
      wb_memtoreg_q <= 1'b0;
      wb_regwrite_q <= 1'b0;
    end else if (!d_stall) begin
      wb_rdata_q    <= is_load ? ld_data : '0;
      wb_alu_q      <= ex_result;
      wb_rd_q       <= ex_rd;
      wb_memtoreg_q <= ex_memtoreg;
      wb_regwrite_q <= ex_regwrite;
    end
  end

  assign wb_rdata    = wb_rdata_q;
  assign wb_alu      = wb_alu_q;
  assign wb_rd       = wb_rd_q;
  assign wb_memtoreg = wb_memtoreg_q;
  assign wb_regwrite = wb_regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed instruction stream with a transaction-level
// model of the expected handshake, request fields and MEM/WB contents.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_result, ex_data2;
  logic [4:0]  ex_rd;
  logic        ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_ls_word;
  logic        dc_req, dc_we, dc_valid, d_stall;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0]  dc_wstrb;
  logic [31:0] wb_rdata, wb_alu;
  logic [4:0]  wb_rd;
  logic        wb_memtoreg, wb_regwrite;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_result(ex_result), .ex_data2(ex_data2), .ex_rd(ex_rd),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_ls_word(ex_ls_word),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wstrb(dc_wstrb),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_valid(dc_valid),
    .d_stall(d_stall),
    .wb_rdata(wb_rdata), .wb_alu(wb_alu), .wb_rd(wb_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite)
  );

  int checks = 0;
  int errors = 0;

  // Expected cycle-level outputs and MEM/WB contents.
  logic        exp_req, exp_stall, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_rd;
  logic        m_memtoreg, m_regwrite;

  int          stall_total = 0;
  int          done_total  = 0;
  int          stall_base, done_base;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_wstrb;
  logic        snap_we;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] rdata,
                                           input logic [31:0] addr,
                                           input logic word);
    int sh;
    if (word) return rdata;
    sh = 8 * (3 - int'(addr[1:0]));
    return 32'($signed(rdata << sh) >>> 24);
  endfunction

  // One instruction through MEM; lat = cycles from request to dc_valid.
  task automatic issue(input logic [31:0] res, input logic [31:0] d2,
                       input logic [4:0] rd, input logic mtr, input logic rw,
                       input logic mr, input logic mw, input logic wd,
                       input int lat, input logic [31:0] rdata, input logic glitch);
    logic acc;
    acc = mr | mw;
    ex_result = res; ex_data2 = d2; ex_rd = rd;
    ex_memtoreg = mtr; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    ex_ls_word = wd;
    e_addr  = res & ~32'h3;
    e_we    = mw;
    e_wstrb = !mw ? 4'h0 : (wd ? 4'hF : 4'(1 << res[1:0]));
    e_wdata = wd ? d2 : 32'(d2[7:0]) * 32'h0101_0101;
    exp_req   = acc;
    exp_stall = acc;
    dc_valid  = glitch;
    dc_rdata  = $urandom;
    for (int c = 1; acc && c <= lat; c++) begin
      @(posedge clk); #1;
      dc_valid  = (c == lat);
      dc_rdata  = (c == lat) ? rdata : $urandom;
      exp_stall = (c != lat);
    end
    @(posedge clk); #1;
    m_alu      = res;
    m_rd       = rd;
    m_memtoreg = mtr;
    m_regwrite = rw;
    m_rdata    = (mr && !mw) ? load_val(rdata, res, wd) : 32'h0;
    dc_valid   = 1'b0;
  endtask

  task automatic nop(input logic [31:0] res, input logic [4:0] rd, input logic glitch);
    issue(res, 32'h0, rd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h0, glitch);
  endtask

  initial begin
    rst = 1'b0;
    ex_result = 32'h100; ex_data2 = 32'h0; ex_rd = 5'd1;
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_ls_word = 1'b1; dc_valid = 1'b0; dc_rdata = 32'h0;
    exp_req = 1'b0; exp_stall = 1'b0; e_we = 1'b0; e_wstrb = 4'h0;
    e_addr = 32'h0; e_wdata = 32'h0;
    m_rdata = 32'h0; m_alu = 32'h0; m_rd = 5'd0; m_memtoreg = 1'b0; m_regwrite = 1'b0;

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk);
        chk("d_stall", 32'(d_stall), 32'(exp_stall));
        chk("dc_req", 32'(dc_req), 32'(exp_req));
        chk("dc_wstrb", 32'(dc_wstrb), 32'(e_wstrb));
        if (exp_req) begin
          chk("dc_we", 32'(dc_we), 32'(e_we));
          chk("dc_addr", dc_addr, e_addr);
          if (e_we) chk("dc_wdata", dc_wdata, e_wdata);
        end
        chk("wb_rdata", wb_rdata, m_rdata);
        chk("wb_alu", wb_alu, m_alu);
        chk("wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("wb_memtoreg", 32'(wb_memtoreg), 32'(m_memtoreg));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(m_regwrite));
        if (d_stall) stall_total++;
        if (dc_req && dc_valid && !d_stall) done_total++;
        if (dc_req) begin
          snap_addr = dc_addr; snap_wdata = dc_wdata;
          snap_wstrb = dc_wstrb; snap_we = dc_we;
        end
      end
    join_none

    // Reset holds request/stall low even with a load presented.
    @(posedge clk); #1;
    chk("rst_dc_req", 32'(dc_req), 32'h0);
    chk("rst_d_stall", 32'(d_stall), 32'h0);
    chk("rst_wb_alu", wb_alu, 32'h0);

    @(posedge clk); #1;
    rst = 1'b1;
    stall_base = stall_total;
    nop(32'h1234, 5'd5, 1'b0);
    chk("alu_wb_alu", wb_alu, 32'h1234);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_regwrite", 32'(wb_regwrite), 32'h1);
    chk("alu_stall_cycles", 32'(stall_total - stall_base), 32'd0);

    // lw, minimum latency
    stall_base = stall_total;
    issue(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 32'hDEAD_BEEF, 1'b0);
    chk("lw_stall_cycles", 32'(stall_total - stall_base), 32'd1);
    chk("lw_wb_rdata", wb_rdata, 32'hDEAD_BEEF);
    chk("lw_wb_memtoreg", 32'(wb_memtoreg), 32'h1);

    // sb to lane 2
    issue(32'h102, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h0, 1'b0);
    chk("sb_addr", snap_addr, 32'h100);
    chk("sb_wstrb", 32'(snap_wstrb), 32'h4);
    chk("sb_wdata", snap_wdata, 32'hABAB_ABAB);
    chk("sb_we", 32'(snap_we), 32'h1);

    // lb from lane 3, latency 3, dc_valid noise during the request cycle
    stall_base = stall_total;
    issue(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 32'h80FF_0000, 1'b1);
    chk("lb_stall_cycles", 32'(stall_total - stall_base), 32'd3);
    chk("lb_wb_rdata", wb_rdata, 32'hFFFF_FF80);

    // Back-to-back lw then sw
    done_base  = done_total;
    stall_base = stall_total;
    issue(32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 32'h1122_3344, 1'b0);
    chk("b2b_lw_rdata", wb_rdata, 32'h1122_3344);
    chk("b2b_lw_rd", 32'(wb_rd), 32'd9);
    issue(32'h204, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h0, 1'b0);
    chk("b2b_sw_rdata", wb_rdata, 32'h0);
    chk("b2b_sw_alu", wb_alu, 32'h204);
    chk("b2b_sw_wdata", snap_wdata, 32'hCAFE_F00D);
    chk("b2b_transactions", 32'(done_total - done_base), 32'd2);
    chk("b2b_stall_cycles", 32'(stall_total - stall_base), 32'd2);

    // Read+write together acts as a byte store; lb from lane 0 positive
    issue(32'h101, 32'h1234_5677, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 32'h0, 1'b0);
    chk("rw_wstrb", 32'(snap_wstrb), 32'h2);
    chk("rw_wdata", snap_wdata, 32'h7777_7777);
    issue(32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'hAAAA_AA7F, 1'b0);
    chk("lb0_wb_rdata", wb_rdata, 32'h0000_007F);

    // dc_valid glitching in IDLE after completion
    nop(32'h77, 5'd2, 1'b1);
    chk("glitch_wb_alu", wb_alu, 32'h77);

    // Reset asserted while waiting on the cache
    ex_result = 32'h400; ex_rd = 5'd3; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_ls_word = 1'b1;
    e_addr = 32'h400; e_we = 1'b0; e_wstrb = 4'h0;
    exp_req = 1'b1; exp_stall = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0;
    m_rdata = 32'h0; m_alu = 32'h0; m_rd = 5'd0; m_memtoreg = 1'b0; m_regwrite = 1'b0;
    #1;
    chk("rstwait_dc_req", 32'(dc_req), 32'h0);
    chk("rstwait_d_stall", 32'(d_stall), 32'h0);
    chk("rstwait_wb_alu", wb_alu, 32'h0);
    chk("rstwait_wb_regwrite", 32'(wb_regwrite), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    stall_base = stall_total;
    nop(32'h55, 5'd3, 1'b0);
    chk("post_rst_wb_alu", wb_alu, 32'h55);
    chk("post_rst_stall", 32'(stall_total - stall_base), 32'd0);
    nop(32'h0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It consumes the EX/MEM pipeline register contents (ALU result, store data, destination register, control bits, word/byte flag) and performs the data-cache handshake for loads and stores. It builds byte-lane strobes, extracts and sign-extends load data, and asserts `d_stall` to freeze the upstream pipeline while an access is outstanding. It also owns the MEM/WB pipeline register that feeds write-back and EX forwarding.

## Interface
- DATA_W, 32, data/address width
- REG_W, 5, register-index width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_result  in  DATA_W  ALU result; memory address for loads/stores
- ex_data2  in  DATA_W  store data
- ex_rd  in  REG_W  destination register
- ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite  in  1 each  control bits from EX/MEM
- ex_ls_word  in  1  1 = word access, 0 = byte access (signed)
- dc_req  out  1  cache request
- dc_we  out  1  1 = write
- dc_addr  out  DATA_W  `{ex_result[DATA_W-1:2], 2'b00}`
- dc_wstrb  out  4  byte write enables, active-high
- dc_wdata  out  DATA_W  write data
- dc_rdata  in  DATA_W  read data, valid with dc_valid
- dc_valid  in  1  access complete
- d_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and this block's MEM/WB register
- wb_rdata, wb_alu  out  DATA_W  registered load data / ALU result
- wb_rd  out  REG_W  registered destination (also the mem_wb_rd forwarding source)
- wb_memtoreg, wb_regwrite  out  1 each  registered control bits

## Operation
- Access = ex_memread | ex_memwrite. If both are set, the access is treated as a write.
- FSM states: IDLE, WAIT.
  - IDLE, no access: dc_req=0 and d_stall=0. The MEM/WB register captures the inputs each edge.
  - IDLE, access: dc_req=1 and d_stall=1, both combinational, same cycle. Next state is WAIT. dc_valid is ignored in IDLE.
  - WAIT: dc_req=1. While dc_valid=0, d_stall=1. When dc_valid=1, d_stall=0; at that edge MEM/WB captures and the next state is IDLE.
- Request fields are combinational from the ex_* inputs. These stay stable because d_stall holds EX/MEM.
- Store, word: dc_wstrb=4'b1111, dc_wdata=ex_data2.
- Store, byte: dc_wstrb = 4'b0001 << ex_result[1:0], dc_wdata={4{ex_data2[7:0]}}.
- Read: dc_wstrb=4'b0000, dc_we=0.
- Load, word: wb_rdata = dc_rdata.
- Load, byte: select byte ex_result[1:0] of dc_rdata and sign-extend it to DATA_W.
- Word accesses ignore ex_result[1:0]; no misalignment trap.
- MEM/WB register: holds while d_stall=1 and loads otherwise. On a non-load, wb_rdata loads 0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. All wb_* outputs are 0. dc_req, dc_we, dc_wstrb and d_stall drop to 0 immediately. Reset in WAIT abandons the access; the cache must tolerate a dropped dc_req.
- Non-memory instruction: 1 cycle in MEM, with no stall.
- Memory access with cache response N ≥ 1 cycles after the request: N+1 cycles in MEM, with d_stall high for N cycles.
- Cache hit at minimum latency (dc_valid in the cycle after the request): 2 cycles in MEM, 1 stall cycle.
- Back-to-back accesses: the next access is seen in IDLE the cycle after completion. There is no idle gap on dc_req other than that one IDLE cycle, during which dc_req stays high.
- dc_valid in IDLE, or glitching after completion, causes no capture.

## Test plan
- Reset release with an ALU op (ex_result=0x1234, ex_rd=5, ex_regwrite=1) -> next edge gives wb_alu=0x1234, wb_rd=5, wb_regwrite=1, and d_stall stays 0.
- lw at 0x100, dc_valid 1 cycle after the request with dc_rdata=0xDEADBEEF -> d_stall high for exactly 1 cycle, then wb_rdata=0xDEADBEEF, wb_memtoreg=1.
- sb at 0x102 with ex_data2=0x000000AB -> dc_addr=0x100, dc_wstrb=4'b0100, dc_wdata=0xABABABAB, dc_we=1.
- lb at 0x103 with dc_rdata=0x80FF0000, dc_valid after 3 cycles -> d_stall high for 3 cycles, then wb_rdata=0xFFFFFF80.
- lw followed by sw with 1-cycle cache latency -> each instruction stalls 1 cycle, two distinct dc_req transactions occur, and the MEM/WB values are correct for each.
- rst=0 in WAIT -> dc_req and d_stall go to 0 asynchronously and the wb_* outputs go to 0. After rst=1 with a non-memory instruction, the FSM is in IDLE and there is no stall.
